dmem_latency_staller: RTL and testbench

- Parametrised data-memory stall controller for the pipelined CPU MEM stage.
- Freezes the pipeline for a configurable number of cycles per memory operation, with separate read and write latencies.
- Correctly separates back-to-back memory ops, ops held in MEM by other hazards, and flushed ops.
- Reports op completion and a saturating stall-cycle performance count.

---
 rtl/dmem_latency_staller.sv | 124 ++++++++++++
 tb/tb_dmem_latency_staller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_latency_staller.sv
// MEM-stage stall controller: freezes the pipeline for a per-op latency (separate load/store),
// pulses mem_done on completion and keeps a saturating count of stalled cycles.
module dmem_latency_staller #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned WR_LAT = 1,
    parameter int unsigned LAT_W  = 4,
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              hold_in,
    input  logic              flush,
    input  logic              perf_clr,
    output logic              MemStall,
    output logic              mem_done,
    output logic              busy,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone, StHold} state_e;

    localparam logic [LAT_W-1:0] RdLat  = LAT_W'(RD_LAT);
    localparam logic [LAT_W-1:0] WrLat  = LAT_W'(WR_LAT);
    localparam logic [LAT_W-1:0] MaxLat = (RdLat > WrLat) ? RdLat : WrLat;

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [PERF_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [LAT_W-1:0]   lat;
    logic               req;
    logic               mem_stall;
    logic               mem_done_c;

    assign req = MemRead | MemWrite;

    always_comb begin
        if (MemRead && MemWrite) begin
            lat = MaxLat;
        end else if (MemRead) begin
            lat = RdLat;
        end else begin
            lat = WrLat;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_stall  = 1'b0;
        mem_done_c = 1'b0;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        if (lat == '0) begin
                            mem_done_c = 1'b1;
                            state_d    = hold_in ? StHold : StIdle;
                        end else begin
                            mem_stall = 1'b1;
                            if (lat == LAT_W'(1)) begin
                                state_d = StDone;
                            end else begin
                                // First stall cycle is this one, so BUSY covers the rest.
                                cnt_d   = lat - LAT_W'(1);
                                state_d = StBusy;
                            end
                        end
                    end
                end
                StBusy: begin
                    mem_stall = 1'b1;
                    if (cnt_q == LAT_W'(1)) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q - LAT_W'(1);
                    end
                end
                StDone: begin
                    mem_done_c = 1'b1;
                    state_d    = hold_in ? StHold : StIdle;
                end
                StHold: begin
                    // Completed op still sits in MEM; must not be restarted.
                    if (!hold_in) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (perf_clr) begin
            stall_cycles_d = '0;
        end else if (mem_stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign MemStall     = mem_stall;
    assign mem_done     = mem_done_c;
    assign busy         = (state_q == StBusy);
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_dmem_latency_staller.sv
// Directed bench for dmem_latency_staller across three parameter sets sharing one stimulus bus.
module tb_dmem_latency_staller;

    logic clk = 1'b0;
    logic reset_n, MemRead, MemWrite, hold_in, flush, perf_clr;

    logic        ms_a, md_a, bz_a;
    logic        ms_b, md_b, bz_b;
    logic        ms_c, md_c, bz_c;
    logic [31:0] sc_a, sc_b;
    logic [2:0]  sc_c;

    int checks = 0;
    int errors = 0;
    int sel    = 0;
    int step_n = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    dmem_latency_staller #(.RD_LAT(3), .WR_LAT(2), .LAT_W(4), .PERF_W(32)) u_a (
        .clk(clk), .reset_n(reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .hold_in(hold_in), .flush(flush), .perf_clr(perf_clr),
        .MemStall(ms_a), .mem_done(md_a), .busy(bz_a), .stall_cycles(sc_a)
    );

    dmem_latency_staller #(.RD_LAT(1), .WR_LAT(0), .LAT_W(4), .PERF_W(32)) u_b (
        .clk(clk), .reset_n(reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .hold_in(hold_in), .flush(flush), .perf_clr(perf_clr),
        .MemStall(ms_b), .mem_done(md_b), .busy(bz_b), .stall_cycles(sc_b)
    );

    dmem_latency_staller #(.RD_LAT(4), .WR_LAT(4), .LAT_W(4), .PERF_W(3)) u_c (
        .clk(clk), .reset_n(reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .hold_in(hold_in), .flush(flush), .perf_clr(perf_clr),
        .MemStall(ms_c), .mem_done(md_c), .busy(bz_c), .stall_cycles(sc_c)
    );

    function automatic logic [2:0] outs(input int s);
        case (s)
            0:       return {ms_a, md_a, bz_a};
            1:       return {ms_b, md_b, bz_b};
            default: return {ms_c, md_c, bz_c};
        endcase
    endfunction

    function automatic logic [31:0] perf(input int s);
        case (s)
            0:       return sc_a;
            1:       return sc_b;
            default: return 32'(sc_c);
        endcase
    endfunction

    // One cycle: drive at negedge, queue the expected {MemStall,mem_done,busy}, compare
    // shortly after, then advance past the next rising edge.
    task automatic step(input logic rd, input logic wr, input logic hd, input logic fl,
                        input logic [2:0] exp_o);
        logic [2:0] obs;
        logic [2:0] expv;
        MemRead  = rd;
        MemWrite = wr;
        hold_in  = hd;
        flush    = fl;
        exp_q.push_back(exp_o);
        #1;
        obs  = outs(sel);
        expv = exp_q.pop_front();
        checks++;
        step_n++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL step%0d dut%0d {stall,done,busy}: got %b expected %b",
                   step_n, sel, obs, expv);
        end
        @(negedge clk);
    endtask

    task automatic chk_sc(input int expv);
        logic [31:0] obs;
        obs = perf(sel);
        checks++;
        assert (obs === 32'(expv)) else begin
            errors++;
            $error("FAIL stall_cycles dut%0d after step%0d: got %0d expected %0d",
                   sel, step_n, obs, expv);
        end
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        hold_in  = 1'b0;
        flush    = 1'b0;
        perf_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        // Instance A: RD_LAT=3, WR_LAT=2.
        sel = 0;
        do_reset();
        step(0, 0, 0, 0, 3'b000);
        chk_sc(0);
        step(1, 0, 0, 0, 3'b100);
        step(1, 0, 0, 0, 3'b101);
        step(1, 0, 0, 0, 3'b101);
        step(1, 0, 0, 0, 3'b010);
        step(0, 0, 0, 0, 3'b000);
        chk_sc(3);
        perf_clr = 1'b1;
        step(0, 0, 0, 0, 3'b000);
        perf_clr = 1'b0;
        chk_sc(0);
        // Back-to-back load then store.
        step(1, 0, 0, 0, 3'b100);
        step(1, 0, 0, 0, 3'b101);
        step(1, 0, 0, 0, 3'b101);
        step(1, 0, 0, 0, 3'b010);
        step(0, 1, 0, 0, 3'b100);
        step(0, 1, 0, 0, 3'b101);
        step(0, 1, 0, 0, 3'b010);
        step(0, 0, 0, 0, 3'b000);
        chk_sc(5);
        // Load+store uses max latency; inputs and hold ignored while busy.
        step(1, 1, 0, 0, 3'b100);
        step(0, 0, 1, 0, 3'b101);
        step(0, 0, 1, 0, 3'b101);
        step(0, 0, 0, 0, 3'b010);
        step(0, 0, 0, 0, 3'b000);
        chk_sc(8);

        // Instance B: RD_LAT=1, WR_LAT=0.
        sel = 1;
        do_reset();
        step(0, 0, 0, 0, 3'b000);
        step(1, 0, 0, 0, 3'b100);
        step(1, 0, 1, 0, 3'b010);
        step(1, 0, 1, 0, 3'b000);
        step(1, 0, 1, 0, 3'b000);
        step(1, 0, 1, 0, 3'b000);
        step(1, 0, 0, 0, 3'b000);
        step(1, 0, 0, 0, 3'b100);
        step(0, 0, 0, 0, 3'b010);
        chk_sc(2);
        perf_clr = 1'b1;
        step(0, 1, 0, 0, 3'b010);
        perf_clr = 1'b0;
        step(0, 1, 0, 0, 3'b010);
        step(0, 1, 0, 0, 3'b010);
        step(0, 1, 1, 0, 3'b010);
        step(0, 1, 0, 0, 3'b000);
        step(0, 1, 0, 0, 3'b010);
        step(0, 1, 0, 1, 3'b000);
        step(0, 0, 0, 0, 3'b000);
        chk_sc(0);

        // Instance C: RD_LAT=WR_LAT=4, PERF_W=3.
        sel = 2;
        do_reset();
        step(0, 0, 0, 0, 3'b000);
        step(1, 0, 0, 0, 3'b100);
        step(1, 0, 0, 0, 3'b101);
        step(1, 0, 0, 1, 3'b001);
        step(1, 0, 0, 0, 3'b100);
        step(1, 0, 0, 0, 3'b101);
        step(1, 0, 0, 0, 3'b101);
        step(1, 0, 0, 0, 3'b101);
        step(1, 0, 0, 0, 3'b010);
        step(0, 0, 0, 0, 3'b000);
        chk_sc(6);
        step(0, 1, 0, 0, 3'b100);
        step(0, 1, 0, 0, 3'b101);
        step(0, 1, 0, 0, 3'b101);
        step(0, 1, 0, 0, 3'b101);
        step(0, 0, 0, 0, 3'b010);
        step(0, 0, 0, 0, 3'b000);
        chk_sc(7);
        // Clear wins over a simultaneous stall increment.
        perf_clr = 1'b1;
        step(1, 0, 0, 0, 3'b100);
        perf_clr = 1'b0;
        chk_sc(0);
        step(1, 0, 0, 0, 3'b101);
        chk_sc(1);
        reset_n = 1'b0;
        step(1, 0, 0, 0, 3'b101);
        reset_n = 1'b1;
        step(0, 0, 0, 0, 3'b000);
        chk_sc(0);
        step(0, 0, 0, 0, 3'b000);
        step(0, 0, 0, 0, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
